// File: rtl/ni_pkg.sv
// ---------------------------------------------------------------------------
// ni_pkg
//   Shared definitions for the network-interface injection path and the
//   router arbiters: flit geometry, the injection arbiter state type, and
//   field extraction helpers for the fixed {dest_gpu_id, payload} flit.
//
//   Flit layout (FLIT_W = 16):
//     [15:10] dest_gpu_id (DEST_W = 6)
//     [ 9: 0] payload     (PAYLOAD_W = 10)
// ---------------------------------------------------------------------------
package ni_pkg;

    localparam int FLIT_W    = 16;
    localparam int DEST_W    = 6;
    localparam int PAYLOAD_W = 10;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [DEST_W-1:0] dest_of(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1 -: DEST_W];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] payload_of(input logic [FLIT_W-1:0] flit);
        return flit[PAYLOAD_W-1:0];
    endfunction

endpackage : ni_pkg

// File: rtl/ni_inject_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans req_i starting at index ptr_i,
//   wrapping modulo NUM_REQ, and returns the first requester found as a
//   one-hot vector. Shared with the router output arbiters.
//
//   Ports:
//     req_i      [NUM_REQ-1:0]  request vector
//     ptr_i      [PTR_W-1:0]    highest-priority index for this pick
//     winner_o   [NUM_REQ-1:0]  one-hot winner, zero when nothing requests
//     any_req_o                 at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               any_req_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   oh_rot;
    logic [2*NUM_REQ-1:0] oh_dbl;
    logic                 found;

    // Rotate the request vector so ptr_i lands on bit 0; a fixed-priority
    // scan from bit 0 then implements the wrap-around search.
    assign req_dbl = {req_i, req_i};
    assign req_rot = NUM_REQ'(req_dbl >> ptr_i);

    always_comb begin
        oh_rot = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_rot[k] && !found) begin
                oh_rot[k] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Rotate the one-hot result back into the original index space.
    assign oh_dbl    = {{NUM_REQ{1'b0}}, oh_rot} << ptr_i;
    assign winner_o  = oh_dbl[NUM_REQ-1:0] | oh_dbl[2*NUM_REQ-1:NUM_REQ];
    assign any_req_o = |req_i;

endmodule : rr_pick

// File: rtl/ni_inject_arbiter.sv
// ---------------------------------------------------------------------------
// ni_inject_arbiter
//   Shares one NI GPU-side injection port among NUM_REQ local requesters.
//   Round-robin arbitration; a granted requester keeps the port for up to
//   MAX_BURST accepted flits, or until it drops valid, so multi-flit
//   transfers stay contiguous. One idle cycle separates consecutive grants.
//   While granted, the owner's data/valid/ready pass through combinationally.
//
//   Optional build macro: ARB_STATS_EN adds flit_count, one saturating
//   16-bit accepted-flit counter per requester.
//
//   Ports:
//     clk        clock, rising edge
//     reset      asynchronous reset, active low
//     req_data   [NUM_REQ*DATA_W-1:0] requester i at [i*DATA_W +: DATA_W]
//     req_valid  [NUM_REQ-1:0]        per-requester flit valid
//     req_ready  [NUM_REQ-1:0]        per-requester accept
//     ni_data    [DATA_W-1:0]         to NI gpu_data_in (zero while idle)
//     ni_valid                        to NI gpu_valid_in
//     ni_ready                        from NI gpu_ready_out
//     grant      [NUM_REQ-1:0]        one-hot owner, zero while idle
//     busy                            high while a grant is held
//     flit_count [NUM_REQ*16-1:0]     (ARB_STATS_EN only) accepted flits
// ---------------------------------------------------------------------------
module ni_inject_arbiter
    import ni_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FLIT_W,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         ni_data,
    output logic                      ni_valid,
    input  logic                      ni_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
`ifdef ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     flit_count
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   burst_q, burst_d;

    logic [NUM_REQ-1:0] pick_winner;
    logic               pick_any;
    logic [PTR_W-1:0]   owner_idx;
    logic [PTR_W-1:0]   ptr_after_owner;
    logic               owner_valid;
    logic               fire;
    logic               last_beat;

    // -----------------------------------------------------------------------
    // Round-robin pick, evaluated every cycle; only consumed in IDLE.
    // -----------------------------------------------------------------------
    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .winner_o  (pick_winner),
        .any_req_o (pick_any)
    );

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
        end
    end

    // -----------------------------------------------------------------------
    // Owner decode and pass-through datapath. grant_q is zero outside GRANT,
    // so every output below collapses to zero while idle or in reset.
    // -----------------------------------------------------------------------
    always_comb begin
        owner_idx = '0;
        ni_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PTR_W'(i);
                ni_data   = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign owner_valid = |(grant_q & req_valid);
    assign ni_valid    = owner_valid;
    assign req_ready   = grant_q & {NUM_REQ{ni_ready}};
    assign grant       = grant_q;
    assign busy        = (state_q == ARB_GRANT);

    assign fire      = owner_valid && ni_ready;
    assign last_beat = (burst_q == CNT_W'(MAX_BURST - 1));

    // Priority after a release moves to the requester just past the owner,
    // so a re-requesting owner waits behind everyone else.
    assign ptr_after_owner = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                 : owner_idx + PTR_W'(1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        burst_d = burst_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    grant_d = pick_winner;
                    burst_d = '0;
                end
            end

            ARB_GRANT: begin
                // Valid retraction and burst exhaustion both release; the
                // stored count therefore never reaches MAX_BURST.
                if (!owner_valid || (fire && last_beat)) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    burst_d = '0;
                    ptr_d   = ptr_after_owner;
                end else if (fire) begin
                    burst_d = burst_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                burst_d = '0;
            end
        endcase
    end

`ifdef ARB_STATS_EN
    // -----------------------------------------------------------------------
    // Per-requester accepted-flit counters, saturating at 16'hFFFF.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (fire && grant_q[g] && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign flit_count[g*16 +: 16] = cnt_q;
    end
`endif

endmodule : ni_inject_arbiter

// File: tb/tb_ni_inject_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ni_inject_arbiter
//   Directed scenarios followed by a randomized phase. Every cycle the DUT
//   outputs are compared with a behavioural reference model that tracks the
//   current owner, burst length and round-robin start index as integers.
// ---------------------------------------------------------------------------
module tb_ni_inject_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   ni_data;
    logic            ni_valid;
    logic            ni_ready;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef ARB_STATS_EN
    logic [N*16-1:0] flit_count;
`endif

    always #5 clk = ~clk;

    ni_inject_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ni_data    (ni_data),
        .ni_valid   (ni_valid),
        .ni_ready   (ni_ready),
        .grant      (grant),
        .busy       (busy)
`ifdef ARB_STATS_EN
        ,
        .flit_count (flit_count)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owner < 0 means idle.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    int m_fired = -1;
    int m_stats [N];

    // Outputs captured during the most recent step.
    logic [N-1:0]  s_grant;
    logic [DW-1:0] s_data;
    logic          s_vld;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_fired = -1;
        for (int i = 0; i < N; i++) m_stats[i] = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},    64'(grant),     64'h0);
        chk({tag, "_ni_valid"}, 64'(ni_valid),  64'h0);
        chk({tag, "_req_ready"},64'(req_ready), 64'h0);
        chk({tag, "_busy"},     64'(busy),      64'h0);
        chk({tag, "_ni_data"},  64'(ni_data),   64'h0);
`ifdef ARB_STATS_EN
        chk({tag, "_flit_count"}, 64'(flit_count), 64'h0);
`endif
    endtask

    // Apply one cycle of inputs, compare outputs with the model, advance the
    // model by the rules of the arbiter, then move past the next rising edge.
    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
        logic [N-1:0]  e_grant;
        logic [N-1:0]  e_rdy;
        logic [DW-1:0] e_data;
        logic          e_vld;
        int            idx;
        logic          rel;

        req_valid = v;
        req_data  = d;
        ni_ready  = r;
        #1;
        if (m_owner < 0) begin
            e_grant = '0;
            e_vld   = 1'b0;
            e_data  = '0;
            e_rdy   = '0;
        end else begin
            e_grant = 4'(1) << m_owner;
            e_vld   = v[m_owner];
            e_data  = d[m_owner*DW +: DW];
            e_rdy   = r ? e_grant : '0;
        end
        chk("grant",     64'(grant),     64'(e_grant));
        chk("ni_valid",  64'(ni_valid),  64'(e_vld));
        chk("ni_data",   64'(ni_data),   64'(e_data));
        chk("req_ready", 64'(req_ready), 64'(e_rdy));
        chk("busy",      64'(busy),      64'(m_owner >= 0));
`ifdef ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("flit_count", 64'(flit_count[i*16 +: 16]), 64'(m_stats[i]));
`endif
        s_grant = grant;
        s_data  = ni_data;
        s_vld   = ni_valid;

        m_fired = -1;
        rel     = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (v[idx] && m_owner < 0) begin
                    m_owner = idx;
                    m_cnt   = 0;
                end
            end
        end else if (!v[m_owner]) begin
            rel = 1'b1;
        end else if (r) begin
            m_fired = m_owner;
            if (m_stats[m_owner] < 65535) m_stats[m_owner]++;
            m_cnt++;
            if (m_cnt == MB) rel = 1'b1;
        end
        if (rel) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cnt   = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N*DW-1:0] d;
        logic [N-1:0]    rv;
        logic [N*DW-1:0] rd;
        logic [N-1:0]    g_exp;
        logic [DW-1:0]   held;

        // ---------------- Reset held with all requesters valid -------------
        reset     = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        ni_ready  = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk_all_zero("rst_c1");
        @(posedge clk); #1;
        chk_all_zero("rst_c2");
        reset = 1'b1;

        // ---------------- Single requester (req1), three flits -------------
        d = '0;
        d[1*DW +: DW] = {6'd5, 10'h2AA};
        step(4'b0010, d, 1'b1);
        chk("s1_idle_grant", 64'(s_grant), 64'h0);
        step(4'b0010, d, 1'b1);
        chk("s1_grant", 64'(s_grant), 64'h2);
        chk("s1_flit0", 64'(s_data), 64'h16AA);
        d[1*DW +: DW] = {6'd7, 10'h3BB};
        step(4'b0010, d, 1'b1);
        chk("s1_flit1", 64'(s_data), 64'h1FBB);
        d[1*DW +: DW] = {6'd2, 10'h0CC};
        step(4'b0010, d, 1'b1);
        chk("s1_flit2", 64'(s_data), 64'h08CC);
        step(4'b0000, d, 1'b1);
        chk("s1_drop_vld", 64'(s_vld), 64'h0);
        step(4'b0000, d, 1'b1);
        chk("s1_idle_again", 64'(s_grant), 64'h0);

        // ---------------- Full contention, starting from ptr=2 -------------
        for (int gi = 0; gi < 5; gi++) begin
            step(4'hF, {$urandom, $urandom}, 1'b1);
            chk("fc_gap", 64'(s_grant), 64'h0);
            g_exp = 4'(1) << ((2 + gi) % N);
            for (int b = 0; b < MB; b++) begin
                step(4'hF, {$urandom, $urandom}, 1'b1);
                chk("fc_owner", 64'(s_grant), 64'(g_exp));
            end
        end
        // Last burst went to req2; ptr is now 3.
        step(4'b0000, '0, 1'b1);

        // ---------------- Backpressure on req0 ------------------------------
        d = '0;
        d[0 +: DW] = 16'hABCD;
        step(4'b0001, d, 1'b1);
        chk("bp_gap", 64'(s_grant), 64'h0);
        step(4'b0001, d, 1'b1);
        step(4'b0001, d, 1'b1);
        held = 16'h1234;
        d[0 +: DW] = held;
        for (int c = 0; c < 5; c++) begin
            step(4'b0001, d, 1'b0);
            chk("bp_grant_hold", 64'(s_grant), 64'h1);
            chk("bp_data_hold",  64'(s_data),  64'(held));
        end
        step(4'b0001, d, 1'b1);
        step(4'b0001, d, 1'b1);
        step(4'b0001, d, 1'b1);
        chk("bp_released", 64'(s_grant), 64'h0);
        step(4'b0000, d, 1'b1);
        step(4'b0000, d, 1'b1);

        // ---------------- Early release of req2 while req3 waits -----------
        d = {$urandom, $urandom};
        step(4'b1100, d, 1'b1);
        step(4'b1100, d, 1'b1);
        chk("er_owner2", 64'(s_grant), 64'h4);
        step(4'b1100, d, 1'b1);
        step(4'b1000, d, 1'b1);
        chk("er_retract", 64'(s_grant), 64'h4);
        step(4'b1000, d, 1'b1);
        chk("er_gap", 64'(s_grant), 64'h0);
        step(4'b1000, d, 1'b1);
        chk("er_owner3", 64'(s_grant), 64'h8);
        step(4'b0000, d, 1'b1);
        step(4'b0000, d, 1'b1);

        // ---------------- Reset during req0's third flit -------------------
        d = {$urandom, $urandom};
        step(4'b0011, d, 1'b1);
        step(4'b0011, d, 1'b1);
        step(4'b0011, d, 1'b1);
        req_valid = 4'b0011;
        ni_ready  = 1'b1;
        #1;
        chk("mr_pre_grant", 64'(grant), 64'h1);
        reset = 1'b0;
        #1;
        chk_all_zero("mr_async");
        model_reset();
        @(posedge clk); #1;
        chk_all_zero("mr_held");
        reset = 1'b1;
        req_valid = 4'b0011;
        step(4'b0011, d, 1'b1);
        step(4'b0011, d, 1'b1);
        chk("mr_first_owner", 64'(s_grant), 64'h1);
        step(4'b0000, d, 1'b1);
        step(4'b0000, d, 1'b1);

        // ---------------- Randomized traffic -------------------------------
        rv = '0;
        rd = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                // A presented flit stays put until it is accepted.
                if (!(rv[i] && m_fired != i)) begin
                    rv[i] = ($urandom_range(0, 2) != 0);
                    rd[i*DW +: DW] = 16'($urandom);
                end
            end
            step(rv, rd, ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ni_inject_arbiter
